// File: rtl/mm_result_drain.sv
// rtl/mm_result_drain.sv - saturating result FIFO and drain stage behind the matrix-multiply engine
//
// Captures C-element write strobes from the engine, clamps each element to a
// signed OUT_W-bit value and queues it with its row/column tag.  The queue is
// drained over a valid/ready stream.  Completion is tracked from the engine's
// finish pulse.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   mm_read, mm_write      engine strobes; read&write together = dimension fetch
//   mm_i, mm_j, mm_data    C element row, column and signed 40-bit value
//   mm_finish              engine completion pulse
//   out_valid/out_ready    result stream handshake
//   out_data/out_row/out_col/out_sat  head entry fields (zero when empty)
//   done                   finish seen and queue drained
//   overflow               sticky: an element was dropped on a full queue
//   count, checksum        pushed-element count and wrapping 48-bit sum
module mm_result_drain #(
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mm_read,
  input  logic             mm_write,
  input  logic [19:0]      mm_i,
  input  logic [19:0]      mm_j,
  input  logic [39:0]      mm_data,
  input  logic             mm_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [19:0]      out_row,
  output logic [19:0]      out_col,
  output logic             out_sat,
  output logic             done,
  output logic             overflow,
  output logic [19:0]      count,
  output logic [47:0]      checksum
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  // Clamp bounds computed wide, then narrowed; OUT_W=40 yields the full
  // 40-bit range so nothing ever clamps.
  localparam logic signed [39:0] SAT_MAX = 40'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [39:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t            state;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       occ;
  logic [AW:0]       occ_next;
  logic              empty;
  logic              full;
  logic              acc;
  logic              pop;
  logic              push;
  logic              drop;
  logic [OUT_W-1:0]  sat_val;
  logic              sat_flag;
  logic [AW-1:0]     rd_idx;

  logic [OUT_W-1:0]  data_mem [DEPTH];
  logic              sat_mem  [DEPTH];
  logic [19:0]       row_mem  [DEPTH];
  logic [19:0]       col_mem  [DEPTH];

  assign occ    = wr_ptr - rd_ptr;
  assign empty  = (occ == '0);
  assign full   = (occ == FULL_OCC);
  assign rd_idx = rd_ptr[AW-1:0];

  // read&write together marks a dimension fetch, never an element.
  assign acc  = mm_write & ~mm_read & (state == COLLECT);
  assign pop  = out_valid & out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push = acc & (~full | pop);
  assign drop = acc & full & ~pop;

  assign occ_next = occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    sat_val  = mm_data[OUT_W-1:0];
    sat_flag = 1'b0;
    if ($signed(mm_data) > SAT_MAX) begin
      sat_val  = SAT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if ($signed(mm_data) < SAT_MIN) begin
      sat_val  = SAT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign out_valid = ~empty;
  assign out_data  = empty ? '0    : data_mem[rd_idx];
  assign out_sat   = empty ? 1'b0  : sat_mem[rd_idx];
  assign out_row   = empty ? 20'd0 : row_mem[rd_idx];
  assign out_col   = empty ? 20'd0 : col_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr[AW-1:0]] <= sat_val;
      sat_mem[wr_ptr[AW-1:0]]  <= sat_flag;
      row_mem[wr_ptr[AW-1:0]]  <= mm_i;
      col_mem[wr_ptr[AW-1:0]]  <= mm_j;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      count    <= 20'd0;
      checksum <= 48'd0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        count    <= count + 20'd1;
        checksum <= checksum + {{8{mm_data[39]}}, mm_data};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        COLLECT: begin
          // Finish is evaluated after this cycle's push/pop.
          if (mm_finish) begin
            if (occ_next != '0) begin
              state <= DRAIN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && occ == {{AW{1'b0}}, 1'b1}) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mm_result_drain.md
# mm_result_drain

Result-side stage directly downstream of the matrix-multiply engine. Captures each 40-bit C-element write strobe (`write`, `i`, `j`, `write_data`), saturates it to the output width, and buffers it in a small FIFO. Drains the FIFO over a valid/ready stream with row/column tags. Tracks completion from the engine's `finish` pulse and reports element count, running checksum and overflow.

## Interface
- `OUT_W`, 32: signed output data width. Legal range is 2..40; 40 disables saturation.
- `DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mm_read` in 1: engine `read` strobe.
- `mm_write` in 1: engine `write` strobe.
- `mm_i` in 20: C row index.
- `mm_j` in 20: C column index.
- `mm_data` in 40: signed C element.
- `mm_finish` in 1: engine completion pulse.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts the head entry.
- `out_data` out OUT_W: saturated signed element.
- `out_row` out 20: row tag.
- `out_col` out 20: column tag.
- `out_sat` out 1: this element was clamped.
- `done` out 1: finish seen and FIFO empty.
- `overflow` out 1: sticky; an element was dropped.
- `count` out 20: elements pushed into the FIFO.
- `checksum` out 48: wrapping sum of pushed elements.

## Operation
- Accept qualifier: `acc = mm_write & ~mm_read & (state==COLLECT)`.
  - The engine raises `read` and `write` together while it fetches dimensions. Those cycles are never elements.
- On `acc`, the block stores {sat(mm_data), sat flag, mm_i, mm_j}.
- Saturation of the signed 40-bit value:
  - value > 2^(OUT_W-1)-1 → store 2^(OUT_W-1)-1 and set the flag.
  - value < -2^(OUT_W-1) → store -2^(OUT_W-1) and set the flag.
  - Otherwise store the truncated value with the flag clear.
- `checksum` adds the full-precision `mm_data`, sign-extended to 48 bits, modulo 2^48.
  - Only pushed elements are added; dropped elements are not.
- `count` increments by 1 per push and wraps at 2^20.
- Pop occurs when `out_valid & out_ready`.
- Push when full:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the element is dropped, `overflow` sets and stays set until reset, and neither `count` nor `checksum` changes.
- Push and pop in the same cycle leave the occupancy unchanged.
- The engine has no backpressure. Elements arrive at most once every 3 cycles.
- States:
  - COLLECT (reset state): accepts elements. On `mm_finish`, go to DRAIN if the FIFO is non-empty after this cycle's push/pop, else DONE.
  - DRAIN: no accepts; all `mm_write` activity is ignored (the engine keeps running out of range after finish). Go to DONE on the cycle the last entry pops.
  - DONE: `done`=1; no accepts; hold until reset.
- `mm_finish` together with `acc` in the same cycle: the element is pushed first, then the state transition is taken.
- `mm_finish` outside COLLECT is ignored.
- Reset at any point, including mid-drain:
  - FIFO is emptied and state returns to COLLECT.
  - Counters and flags are cleared.
  - Any partially consumed stream is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_sat`=0, `done`=0, `overflow`=0, `count`=0, `checksum`=0.
- Latency: an element accepted at edge N appears with `out_valid`=1 after edge N, i.e. one cycle later, when the FIFO was empty.
- `count` and `checksum` update at the same edge as the push.
- While `out_valid & ~out_ready`, the head fields stay stable and `out_valid` stays high.
- `out_valid` never drops without a pop.
- `done` rises at the edge after the final pop, or at the edge after `mm_finish` when the FIFO is already empty.
- Full throughput is one pop per cycle. With `out_ready` tied high and engine spacing of 3 or more cycles, overflow never occurs.

## Test plan
- 2x2 result, values {5, -7, 1<<35, -(1<<35)}, OUT_W=32, `out_ready`=1:
  - Output sequence: 5, -7, 2147483647 (sat=1), -2147483648 (sat=1).
  - Tags (0,0), (0,1), (1,0), (1,1).
  - `count`=4, `checksum`=-2 mod 2^48.
  - `done` rises 1 cycle after the last pop.
- Dimension-fetch cycles with `mm_read`=`mm_write`=1 and data 2, 3, 2 → nothing pushed; `count` stays 0.
- `out_ready`=0, 6 writes spaced 3 cycles, DEPTH=4:
  - First 4 are stored; writes 5 and 6 are dropped.
  - `overflow`=1, `count`=4.
  - Releasing `out_ready` drains exactly 4 entries in order.
- FIFO full with `out_ready`=1 pulsed in the same cycle as a write → push succeeds; occupancy stays 4; `overflow` stays 0.
- `mm_finish` with 2 entries queued, followed by more `mm_write` strobes → those strobes are ignored; state is DRAIN until 2 pops, then `done`=1.
- Reset asserted mid-drain with 3 entries queued → next cycle all outputs are 0 and state is COLLECT; a new write appears 1 cycle after it is accepted.
